violation_reset_seq: RTL and testbench

VIOLATION_RESET_SEQ -- requirements
Module: violation_reset_seq

---
 rtl/violation_reset_seq.sv | 95 +++++++++
 tb/tb_violation_reset_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/violation_reset_seq.sv
// Turns per-source violation requests into a held system reset.
// The reset is released only once the core is seen fetching from the reset handler.
module violation_reset_seq #(
    parameter int          NUM_SRC       = 4,
    parameter int          MIN_HOLD      = 16,
    parameter logic [15:0] RESET_HANDLER = 16'hFFFE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] kill_req,
    input  logic [15:0]        pc,
    input  logic               pc_en,
    input  logic               clr_cause,
    output logic               sys_reset,
    output logic [NUM_SRC-1:0] cause,
    output logic [7:0]         viol_count,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WAIT_PC
    } state_t;

    localparam logic [7:0] HOLD_INIT = 8'(MIN_HOLD - 1);

    state_t     state;
    logic [7:0] hold_cnt;

    logic kill_any;
    logic at_handler;

    assign kill_any   = |kill_req;
    assign at_handler = pc_en && (pc == RESET_HANDLER);
    assign busy       = (state != IDLE);

    // A new kill while waiting for the handler fetch restarts the full hold window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sys_reset  <= 1'b0;
            cause      <= '0;
            viol_count <= 8'd0;
            hold_cnt   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (kill_any) begin
                        state     <= HOLD;
                        sys_reset <= 1'b1;
                        cause     <= kill_req;
                        hold_cnt  <= HOLD_INIT;
                        if (viol_count != 8'hFF) begin
                            viol_count <= viol_count + 8'd1;
                        end
                    end else if (clr_cause) begin
                        cause <= '0;
                    end
                end

                HOLD: begin
                    sys_reset <= 1'b1;
                    cause     <= cause | kill_req;
                    if (hold_cnt == 8'd0) begin
                        state <= WAIT_PC;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end

                WAIT_PC: begin
                    if (kill_any) begin
                        state     <= HOLD;
                        sys_reset <= 1'b1;
                        cause     <= cause | kill_req;
                        hold_cnt  <= HOLD_INIT;
                        if (viol_count != 8'hFF) begin
                            viol_count <= viol_count + 8'd1;
                        end
                    end else if (at_handler) begin
                        state     <= IDLE;
                        sys_reset <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    sys_reset <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_violation_reset_seq.sv
// Self-checking bench for violation_reset_seq: directed scenarios plus random
// stimulus compared each cycle against a behavioural model.
module tb_violation_reset_seq;

    localparam int          NUM_SRC  = 4;
    localparam int          MIN_HOLD = 16;
    localparam logic [15:0] RH       = 16'hFFFE;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   kill_req;
    logic [15:0]  pc;
    logic         pc_en;
    logic         clr_cause;
    logic         sys_reset;
    logic [3:0]   cause;
    logic [7:0]   viol_count;
    logic         busy;

    int errors = 0;
    int checks = 0;

    // Model: "in reset" flag, remaining hold edges, sticky cause, event count.
    bit         m_reset;
    int         m_hold_left;
    logic [3:0] m_cause;
    int         m_count;

    violation_reset_seq #(
        .NUM_SRC(NUM_SRC),
        .MIN_HOLD(MIN_HOLD),
        .RESET_HANDLER(RH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .kill_req(kill_req),
        .pc(pc),
        .pc_en(pc_en),
        .clr_cause(clr_cause),
        .sys_reset(sys_reset),
        .cause(cause),
        .viol_count(viol_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_reset     = 1'b0;
        m_hold_left = 0;
        m_cause     = 4'd0;
        m_count     = 0;
    endtask

    task automatic modelStep(input logic [3:0] k, input logic [15:0] p, input logic e, input logic c);
        if (!m_reset) begin
            if (k != 4'd0) begin
                m_reset     = 1'b1;
                m_hold_left = MIN_HOLD;
                m_cause     = k;
                m_count     = (m_count < 255) ? m_count + 1 : 255;
            end else if (c) begin
                m_cause = 4'd0;
            end
        end else if (m_hold_left > 0) begin
            m_hold_left = m_hold_left - 1;
            m_cause     = m_cause | k;
        end else begin
            if (k != 4'd0) begin
                m_hold_left = MIN_HOLD;
                m_cause     = m_cause | k;
                m_count     = (m_count < 255) ? m_count + 1 : 255;
            end else if (e && p == RH) begin
                m_reset = 1'b0;
            end
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".sys_reset"}, 32'(sys_reset), 32'(m_reset));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(m_reset));
        checkOutput({tag, ".cause"}, 32'(cause), 32'(m_cause));
        checkOutput({tag, ".viol_count"}, 32'(viol_count), 32'(m_count));
    endtask

    task automatic applyStimulus(input logic [3:0] k, input logic [15:0] p, input logic e, input logic c);
        kill_req  = k;
        pc        = p;
        pc_en     = e;
        clr_cause = c;
        @(posedge clk);
        modelStep(k, p, e, c);
        #1;
        checkAll("cycle");
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        modelReset();
        #2;
        checkAll("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One kill pulse followed by the full hold; leaves the DUT waiting for the handler.
    task automatic runKill(input logic [3:0] k);
        applyStimulus(k, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < MIN_HOLD; i++) applyStimulus(4'd0, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        kill_req  = 4'd0;
        pc        = 16'h0;
        pc_en     = 1'b0;
        clr_cause = 1'b0;
        doReset();

        // Single kill, release attempts during hold and with pc_en low, then release.
        applyStimulus(4'b0001, 16'h0, 1'b0, 1'b0);
        checkOutput("kill_rise", 32'(sys_reset), 32'd1);
        checkOutput("kill_count", 32'(viol_count), 32'd1);
        for (int i = 1; i < 20; i++) begin
            applyStimulus(4'd0, (i == 5 || i == 18) ? RH : 16'h0, (i == 5), 1'b0);
            checkOutput("held", 32'(sys_reset), 32'd1);
        end
        applyStimulus(4'd0, RH, 1'b1, 1'b0);
        checkOutput("release", 32'(sys_reset), 32'd0);
        checkOutput("release_busy", 32'(busy), 32'd0);

        // Cause accumulation in hold and re-arm beating release in wait.
        doReset();
        applyStimulus(4'b0001, 16'h0, 1'b0, 1'b0);
        applyStimulus(4'd0, 16'h0, 1'b0, 1'b0);
        applyStimulus(4'b0100, 16'h0, 1'b0, 1'b0);
        checkOutput("or_cause", 32'(cause), 32'h5);
        checkOutput("or_count", 32'(viol_count), 32'd1);
        for (int i = 0; i < MIN_HOLD - 2; i++) applyStimulus(4'd0, 16'h0, 1'b0, 1'b0);
        applyStimulus(4'b1000, RH, 1'b1, 1'b0);
        checkOutput("rearm_cause", 32'(cause), 32'hD);
        checkOutput("rearm_count", 32'(viol_count), 32'd2);
        checkOutput("rearm_reset", 32'(sys_reset), 32'd1);
        for (int i = 0; i < MIN_HOLD; i++) applyStimulus(4'd0, 16'h0, 1'b0, 1'b0);
        applyStimulus(4'd0, RH, 1'b1, 1'b0);

        // clr_cause ignored while busy, honoured in idle, loses to a kill.
        doReset();
        runKill(4'b0001);
        applyStimulus(4'd0, 16'h0, 1'b0, 1'b1);
        checkOutput("clr_busy", 32'(cause), 32'h1);
        applyStimulus(4'd0, RH, 1'b1, 1'b0);
        applyStimulus(4'd0, 16'h0, 1'b0, 1'b1);
        checkOutput("clr_idle", 32'(cause), 32'h0);
        applyStimulus(4'b0010, 16'h0, 1'b0, 1'b1);
        checkOutput("clr_kill", 32'(cause), 32'h2);
        for (int i = 0; i < MIN_HOLD; i++) applyStimulus(4'd0, 16'h0, 1'b0, 1'b0);
        applyStimulus(4'd0, RH, 1'b1, 1'b0);

        // Saturation of the event counter.
        doReset();
        for (int n = 0; n < 300; n++) begin
            runKill(4'(1 << (n % 4)));
            applyStimulus(4'd0, RH, 1'b1, 1'b0);
        end
        checkOutput("saturate", 32'(viol_count), 32'hFF);
        doReset();
        checkOutput("sat_cleared", 32'(viol_count), 32'h0);

        // Asynchronous abort in the middle of a hold.
        applyStimulus(4'b0011, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(4'd0, 16'h0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        modelReset();
        #2;
        checkOutput("async_reset", 32'(sys_reset), 32'd0);
        checkOutput("async_busy", 32'(busy), 32'd0);
        checkOutput("async_cause", 32'(cause), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runKill(4'b0100);
        applyStimulus(4'd0, RH, 1'b1, 1'b0);

        // Random traffic with occasional asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            logic [3:0]  k;
            logic [15:0] p;
            k = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            p = ($urandom_range(0, 3) == 0) ? RH : 16'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                #($urandom_range(1, 3));
                doReset();
            end
            applyStimulus(k, p, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
